// File: rtl/csa_pkg.sv
// Shared constants and types for the wide-operand CSA word sequencer.
package csa_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage : csa_pkg

// File: rtl/FourCSA.sv
// 8-bit carry-select adder slice: two 4-bit halves, upper half precomputed for both carries.
module FourCSA (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] S,
    output logic       Cout
);

    logic [4:0] w_lo;
    logic [4:0] w_hi0;
    logic [4:0] w_hi1;

    assign w_lo  = {1'b0, A[3:0]} + {1'b0, B[3:0]} + {4'b0000, Cin};
    assign w_hi0 = {1'b0, A[7:4]} + {1'b0, B[7:4]};
    assign w_hi1 = {1'b0, A[7:4]} + {1'b0, B[7:4]} + 5'd1;

    // Low-half carry picks which precomputed upper half is the real one.
    assign S    = {(w_lo[4] ? w_hi1[3:0] : w_hi0[3:0]), w_lo[3:0]};
    assign Cout = w_lo[4] ? w_hi1[4] : w_hi0[4];

endmodule : FourCSA

// File: rtl/csa_word_sequencer.sv
// Sequences a WIDTH-bit add through one 8-bit FourCSA slice per cycle, LSB slice first,
// with valid/ready handshakes on both sides and fully registered results.
module csa_word_sequencer
    import csa_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_width_check
        $error("csa_word_sequencer: WIDTH must be a multiple of 8 and at least 8");
    end

    seq_state_t         r_state;
    logic [IDXW-1:0]    r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_out_valid;
    logic               r_in_ready;

    logic [SLICE_W-1:0] w_a_slice;
    logic [SLICE_W-1:0] w_b_slice;
    logic [SLICE_W-1:0] w_s;
    logic               w_cout;
    logic               w_last;

    assign w_a_slice = r_a[int'(r_idx) * SLICE_W +: SLICE_W];
    assign w_b_slice = r_b[int'(r_idx) * SLICE_W +: SLICE_W];
    assign w_last    = (r_idx == IDXW'(NSLICE - 1));

    FourCSA u_slice (
        .A    (w_a_slice),
        .B    (w_b_slice),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_cout)
    );

    // Handshake FSM, slice chaining and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // r_in_ready gates the accept so the reset-release edge never takes operands.
                    if (r_in_ready && in_valid) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_carry    <= in_cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    r_sum[int'(r_idx) * SLICE_W +: SLICE_W] <= w_s;
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_cout      <= w_cout;
                        r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[SLICE_W-1] != r_a[WIDTH-1]);
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;

endmodule : csa_word_sequencer

// File: tb/tb_csa_word_sequencer.sv
// Directed-vector and randomised bench for csa_word_sequencer at WIDTH=32.
module tb_csa_word_sequencer;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           hold;
    } vec_t;

    vec_t vecs [8];

    csa_word_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic [W-1:0] es, input logic ec, input logic eo,
                           input int hold, input bit rnd);
        int n;
        bit seen;
        logic [W-1:0] hs;
        logic hc, ho;
        in_a = a; in_b = b; in_cin = cin;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_wait", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
        chk("in_ready_run", {63'd0, in_ready}, 64'd0);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            if (rnd) begin
                in_valid  = 1'($urandom);
                out_ready = 1'($urandom);
            end
            @(posedge clk); #1; n++;
            seen = out_valid;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("latency", 64'(n), 64'd4);
        chk("sum", {32'd0, out_sum}, {32'd0, es});
        chk("cout", {63'd0, out_cout}, {63'd0, ec});
        chk("ovf", {63'd0, out_ovf}, {63'd0, eo});
        chk("in_ready_done", {63'd0, in_ready}, 64'd0);
        hs = out_sum; hc = out_cout; ho = out_ovf;
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == hold / 2);
            in_a = $urandom; in_b = $urandom;
            @(posedge clk); #1;
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_stable", {30'd0, out_cout, out_ovf, out_sum}, {30'd0, hc, ho, hs});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("pop_valid", {63'd0, out_valid}, 64'd0);
        chk("pop_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [W:0]   ref_s;
        logic [W-1:0] ra, rb;
        logic         rc;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 0};
        vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1};
        vecs[2] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0, 2};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 10};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 0};
        vecs[5] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 0};
        vecs[6] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 3};
        vecs[7] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 0};

        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_a = 32'h00000005; in_b = 32'h00000003; in_cin = 1'b0;
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_sum", {32'd0, out_sum}, 64'd0);
        #19 rst_n = 1'b1;
        // First edge after release must not take the pending in_valid.
        @(posedge clk); #1;
        chk("release_ready", {63'd0, in_ready}, 64'd1);
        chk("release_valid", {63'd0, out_valid}, 64'd0);
        run_txn(32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
                    vecs[i].hold, 1'b0);
        end

        // Reset two cycles into RUN discards the transaction.
        in_a = 32'hDEADBEEF; in_b = 32'h12345678; in_cin = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrun_rst_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        chk("midrun_rst_valid2", {63'd0, out_valid}, 64'd0);
        chk("midrun_rst_ready2", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrun_rel_ready", {63'd0, in_ready}, 64'd1);
        chk("midrun_rel_outs", {30'd0, out_valid, out_cout, out_ovf, out_sum}, 64'd0);
        run_txn(32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0, 0, 1'b0);

        for (int t = 0; t < 200; t++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            ref_s = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            run_txn(ra, rb, rc, ref_s[W-1:0], ref_s[W],
                    (ra[W-1] == rb[W-1]) && (ref_s[W-1] != ra[W-1]),
                    int'($urandom_range(0, 3)), 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_csa_word_sequencer

// File: doc/csa_word_sequencer.md
Name: csa_word_sequencer

Overview:
- Wide-operand adder front end: accepts WIDTH-bit A/B/Cin via valid/ready and drives one FourCSA 8-bit slice per cycle, least-significant first.
- Chains the carry between slices in a register and assembles the WIDTH-bit sum, carry-out and signed overflow.
- Presents the result on a valid/ready output port.
- Sits directly upstream of FourCSA, which is instantiated as its only sub-module.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of 8 and at least 8 (elaboration-time assertion).
- NSLICE, WIDTH/8, derived slice count; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  A+B+Cin, low WIDTH bits
- out_cout  output  1  carry-out of bit WIDTH-1
- out_ovf  output  1  signed overflow

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, idx=0, carry_q=0.
  - Operand, sum, cout and ovf registers cleared to 0.
  - out_valid=0, in_ready=1 from the first cycle after release.
- State IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid=1, latch in_a, in_b and in_cin (into carry_q), set idx=0 and go to RUN.
- State RUN:
  - in_ready=0, out_valid=0.
  - FourCSA inputs: A=a_q[idx*8+:8], B=b_q[idx*8+:8], Cin=carry_q.
  - Each cycle: sum_q[idx*8+:8] <= S, carry_q <= Cout, idx <= idx+1.
  - When idx==NSLICE-1: go to DONE and register out_cout=Cout.
  - Also register out_ovf = (a_q[WIDTH-1]==b_q[WIDTH-1]) && (S[7]!=a_q[WIDTH-1]).
- State DONE:
  - out_valid=1, in_ready=0.
  - out_sum, out_cout and out_ovf stay stable while out_ready=0.
  - When out_ready=1, go to IDLE.
- Latency and throughput:
  - out_valid rises exactly NSLICE cycles after the accept edge (4 for WIDTH=32).
  - One transaction per NSLICE+2 cycles; no overlap between transactions.
- Input and output rules:
  - in_valid is ignored outside IDLE.
  - Inputs may change freely after the accept edge.
  - Outputs are registered only; no combinational path from in_* to out_*.
- idx is $clog2(NSLICE)-bit (minimum 1 bit). It is never incremented past NSLICE-1: it resets to 0 on accept, so it never wraps.
- Boundary cases:
  - in_valid asserted on the same edge as reset release: not accepted; first accept is the next edge.
  - Reset mid-RUN or mid-DONE: transaction discarded, out_valid drops immediately (async), no partial result is ever presented.
  - WIDTH=8: RUN lasts exactly one cycle.
  - out_ready held high in IDLE/RUN: no effect.

Decomposition:
- Package csa_pkg holds:
  - SLICE_W=8 constant.
  - seq_state_t enum {IDLE, RUN, DONE}, 2-bit.
- Sub-module: one FourCSA instance, reused unchanged; no other hierarchy.
- Slice mux, sum write-back and overflow logic stay inline.

Test Plan:
- Carry ripple: 0xFFFFFFFF + 0x00000001, cin=0 -> out_sum=0x00000000, out_cout=1, out_ovf=0; out_valid rises 4 cycles after accept.
- Signed overflow: 0x7FFFFFFF + 0x00000001, cin=0 -> out_sum=0x80000000, out_cout=0, out_ovf=1.
- Carry-in path: 0x12345678 + 0x11111111, cin=1 -> out_sum=0x2345678A, out_cout=0, out_ovf=0.
- Backpressure: result for 0x80000000+0x80000000 (sum 0x00000000, cout=1, ovf=1) is held with out_ready=0 for 10 cycles. Required: outputs stable, in_ready=0, and an in_valid pulse during the hold is not accepted.
- Reset mid-RUN: assert rst_n=0 two cycles after accept. Required: out_valid=0 and in_ready=0 while in reset; in_ready=1 and all out_* =0 after release. A following 0x00000005+0x00000003 then gives 0x00000008.
- Randomised back-to-back: 200 transactions with random in_valid/out_ready, compared against a reference model of A+B+Cin (WIDTH+1 bits) and the overflow formula.
